// File: rtl/decode.sv
// ---------------------------------------------------------------------------
// decode -- instruction decode stage of the 15-bit CPU.
//
// Splits the registered instruction word from fetch into registered fields
// and one-hot control strobes. It also tracks slot validity after reset and
// after taken jumps, latches the halt condition, and counts retired
// instructions.
//
// Ports:
//   CLK_DC     in   stage clock (same frequency/phase as CLK_FT)
//   RESET      in   synchronous, active-high reset
//   EN         in   advance enable; low holds every output
//   FLUSH      in   taken jump/branch, squash wrong-path slots
//   PROM_OUT   in   15-bit instruction word from fetch
//   VALID      out  decoded slot holds a real instruction
//   OP_CODE    out  instr[14:11]
//   REG_A      out  instr[10:8]
//   REG_B      out  instr[7:5]
//   IMM        out  instr[7:0]
//   ALU_EN, LD_IMM, CMP_EN, BR_EQ, JMP, MEM_RD, MEM_WR, WB_EN
//              out  one-hot control strobes (WB_EN overlaps)
//   HALTED     out  sticky, set once hlt has been decoded
//   INSTR_CNT  out  count of valid decoded instructions (wraps)
// ---------------------------------------------------------------------------
module decode #(
  parameter int CNT_W       = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              CLK_DC,
  input  logic              RESET,
  input  logic              EN,
  input  logic              FLUSH,
  input  logic [14:0]       PROM_OUT,
  output logic              VALID,
  output logic [3:0]        OP_CODE,
  output logic [2:0]        REG_A,
  output logic [2:0]        REG_B,
  output logic [7:0]        IMM,
  output logic              ALU_EN,
  output logic              LD_IMM,
  output logic              CMP_EN,
  output logic              BR_EQ,
  output logic              JMP,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic              WB_EN,
  output logic              HALTED,
  output logic [CNT_W-1:0]  INSTR_CNT
);

  typedef enum logic [1:0] {
    ST_PRIME = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  // Squash count loaded on FLUSH; with EN high the current slot is already
  // the first squashed one, hence the minus-one variant.
  localparam logic [1:0] FD_FULL_S = 2'(FLUSH_DEPTH);
  localparam logic [1:0] FD_M1_S   = 2'(FLUSH_DEPTH - 1);

  localparam logic [3:0] OP_HLT = 4'b1111;

  // Strobe vector order: {ALU_EN, LD_IMM, CMP_EN, BR_EQ, JMP, MEM_RD, MEM_WR, WB_EN}
  function automatic logic [7:0] strobes_f(input logic [3:0] op);
    logic [7:0] s;
    casez (op)
      4'b0???: s = 8'b1000_0001;  // mov/add/sub/and/or/sl/sr/sra
      4'b100?: s = 8'b0100_0001;  // ldl/ldh
      4'b1010: s = 8'b0010_0000;  // cmp
      4'b1011: s = 8'b0001_0000;  // je
      4'b1100: s = 8'b0000_1000;  // jmp
      4'b1101: s = 8'b0000_0101;  // ld
      4'b1110: s = 8'b0000_0010;  // st
      default: s = 8'b0000_0000;  // hlt drives no strobe
    endcase
    return s;
  endfunction

  state_t            state_r,  state_s;
  logic [1:0]        squash_r, squash_s;
  logic              valid_r,  valid_s;
  logic [3:0]        op_r,     op_s;
  logic [2:0]        rega_r,   rega_s;
  logic [2:0]        regb_r,   regb_s;
  logic [7:0]        imm_r,    imm_s;
  logic [7:0]        strb_r,   strb_s;
  logic              halted_r, halted_s;
  logic [CNT_W-1:0]  cnt_r,    cnt_s;

  // Next-state and next-output logic for the PRIME/RUN/HALT machine.
  always_comb begin
    state_s  = state_r;
    squash_s = squash_r;
    valid_s  = valid_r;
    op_s     = op_r;
    rega_s   = rega_r;
    regb_s   = regb_r;
    imm_s    = imm_r;
    strb_s   = strb_r;
    halted_s = halted_r;
    cnt_s    = cnt_r;

    case (state_r)
      ST_HALT: begin
        // Absorbing: only the slot validity and strobes drop after hlt.
        valid_s = 1'b0;
        strb_s  = 8'h00;
      end

      ST_PRIME, ST_RUN: begin
        if (FLUSH) begin
          // FLUSH wins over any hlt on PROM_OUT and reloads (not adds to)
          // the squash counter.
          if (EN) begin
            squash_s = FD_M1_S;
            valid_s  = 1'b0;
            strb_s   = 8'h00;
            state_s  = ST_RUN;
          end else begin
            squash_s = FD_FULL_S;
          end
        end else if (EN) begin
          if (state_r == ST_PRIME) begin
            // ROM output register has no reset: its first word is garbage.
            valid_s = 1'b0;
            strb_s  = 8'h00;
            state_s = ST_RUN;
          end else if (squash_r != 2'd0) begin
            valid_s  = 1'b0;
            strb_s   = 8'h00;
            squash_s = squash_r - 2'd1;
          end else begin
            valid_s = 1'b1;
            op_s    = PROM_OUT[14:11];
            rega_s  = PROM_OUT[10:8];
            regb_s  = PROM_OUT[7:5];
            imm_s   = PROM_OUT[7:0];
            strb_s  = strobes_f(PROM_OUT[14:11]);
            cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (PROM_OUT[14:11] == OP_HLT) begin
              halted_s = 1'b1;
              state_s  = ST_HALT;
            end else begin
              state_s  = ST_RUN;
            end
          end
        end else begin
          state_s = state_r;
        end
      end

      default: begin
        state_s = ST_PRIME;
        valid_s = 1'b0;
        strb_s  = 8'h00;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_DC) begin
    if (RESET) begin
      state_r  <= ST_PRIME;
      squash_r <= 2'd0;
      valid_r  <= 1'b0;
      op_r     <= 4'd0;
      rega_r   <= 3'd0;
      regb_r   <= 3'd0;
      imm_r    <= 8'd0;
      strb_r   <= 8'd0;
      halted_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      squash_r <= squash_s;
      valid_r  <= valid_s;
      op_r     <= op_s;
      rega_r   <= rega_s;
      regb_r   <= regb_s;
      imm_r    <= imm_s;
      strb_r   <= strb_s;
      halted_r <= halted_s;
      cnt_r    <= cnt_s;
    end
  end

  assign VALID     = valid_r;
  assign OP_CODE   = op_r;
  assign REG_A     = rega_r;
  assign REG_B     = regb_r;
  assign IMM       = imm_r;
  assign ALU_EN    = strb_r[7];
  assign LD_IMM    = strb_r[6];
  assign CMP_EN    = strb_r[5];
  assign BR_EQ     = strb_r[4];
  assign JMP       = strb_r[3];
  assign MEM_RD    = strb_r[2];
  assign MEM_WR    = strb_r[1];
  assign WB_EN     = strb_r[0];
  assign HALTED    = halted_r;
  assign INSTR_CNT = cnt_r;

endmodule
